// File: rtl/lc3_fetch_sequencer.sv
// ============================================================================
// lc3_fetch_sequencer : LC-3 fetch/decode control FSM. Handles BR, JMP/RET and
//    JSR/JSRR in-house and hands other opcodes to the execute controller.
//    Optional macro LC3_PAUSE_IR_EN adds a single-step pause after IR load.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc3_fetch_sequencer #(
   parameter int MEM_WAIT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        i_Run,
   input  logic        i_Continue,
   input  logic [15:0] i_IR,
   input  logic [2:0]  i_nzp,
   input  logic        i_exec_done,
   output logic        o_exec_req,
   output logic        o_LD_MAR,
   output logic        o_LD_MDR,
   output logic        o_LD_IR,
   output logic        o_LD_PC,
   output logic        o_LD_REG,
   output logic        o_GatePC,
   output logic        o_GateMDR,
   output logic [1:0]  o_PCMUX,
   output logic        o_ADDR1MUX,
   output logic [1:0]  o_ADDR2MUX,
   output logic        o_DRMUX,
   output logic        o_Mem_OE,
   output logic [3:0]  o_state_dbg
);

   localparam int c_CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(MEM_WAIT - 1);

   localparam logic [3:0] c_HALTED     = 4'd0;
   localparam logic [3:0] c_FETCH1     = 4'd1;
   localparam logic [3:0] c_FETCH2     = 4'd2;
   localparam logic [3:0] c_FETCH3     = 4'd3;
   localparam logic [3:0] c_DECODE     = 4'd4;
   localparam logic [3:0] c_BR_TAKE    = 4'd5;
   localparam logic [3:0] c_JMP        = 4'd6;
   localparam logic [3:0] c_JSR_LINK   = 4'd7;
   localparam logic [3:0] c_JSR_TARGET = 4'd8;
   localparam logic [3:0] c_EXEC_WAIT  = 4'd9;
   localparam logic [3:0] c_PAUSE      = 4'd10;
`ifdef LC3_PAUSE_IR_EN
   localparam logic [3:0] c_PAUSE_IR   = 4'd11;
`endif

   localparam logic [3:0] c_OP_BR  = 4'b0000;
   localparam logic [3:0] c_OP_JSR = 4'b0100;
   localparam logic [3:0] c_OP_JMP = 4'b1100;
   localparam logic [3:0] c_OP_PSE = 4'b1101;

   logic [3:0]      r_state;
   logic [3:0]      w_state_nxt;
   logic [c_CW-1:0] r_wait;
   logic            r_cont_q;
   logic            w_cont_rise;
   logic            w_ben;
   logic [3:0]      w_after;
   logic            w_unused;

   assign w_cont_rise = i_Continue & ~r_cont_q;
   assign w_ben       = |(i_IR[11:9] & i_nzp);
   // Run is only consulted at instruction boundaries, so dropping it mid-instruction finishes the instruction.
   assign w_after     = i_Run ? c_FETCH1 : c_HALTED;
   assign w_unused    = &{1'b0, i_IR[8:0]};
   assign o_state_dbg = r_state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= c_HALTED;
         r_wait   <= '0;
         r_cont_q <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cont_q <= i_Continue;
         if (r_state == c_FETCH2 && r_wait != c_WAIT_LAST)
            r_wait <= r_wait + c_CW'(1);
         else
            r_wait <= '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_HALTED:     if (i_Run) w_state_nxt = c_FETCH1;
         c_FETCH1:     w_state_nxt = c_FETCH2;
         c_FETCH2:     if (r_wait == c_WAIT_LAST) w_state_nxt = c_FETCH3;
`ifdef LC3_PAUSE_IR_EN
         c_FETCH3:     w_state_nxt = c_PAUSE_IR;
         c_PAUSE_IR:   if (w_cont_rise) w_state_nxt = c_DECODE;
`else
         c_FETCH3:     w_state_nxt = c_DECODE;
`endif
         c_DECODE: begin
            case (i_IR[15:12])
               c_OP_BR:  w_state_nxt = w_ben ? c_BR_TAKE : w_after;
               c_OP_JMP: w_state_nxt = c_JMP;
               c_OP_JSR: w_state_nxt = c_JSR_LINK;
               c_OP_PSE: w_state_nxt = c_PAUSE;
               default:  w_state_nxt = c_EXEC_WAIT;
            endcase
         end
         c_BR_TAKE:    w_state_nxt = w_after;
         c_JMP:        w_state_nxt = w_after;
         c_JSR_LINK:   w_state_nxt = c_JSR_TARGET;
         c_JSR_TARGET: w_state_nxt = w_after;
         c_EXEC_WAIT:  if (i_exec_done) w_state_nxt = w_after;
         c_PAUSE:      if (w_cont_rise) w_state_nxt = w_after;
         default:      w_state_nxt = c_HALTED;
      endcase
   end

   always_comb begin
      o_exec_req = 1'b0;
      o_LD_MAR   = 1'b0;
      o_LD_MDR   = 1'b0;
      o_LD_IR    = 1'b0;
      o_LD_PC    = 1'b0;
      o_LD_REG   = 1'b0;
      o_GatePC   = 1'b0;
      o_GateMDR  = 1'b0;
      o_PCMUX    = 2'b00;
      o_ADDR1MUX = 1'b0;
      o_ADDR2MUX = 2'b00;
      o_DRMUX    = 1'b0;
      o_Mem_OE   = 1'b0;
      case (r_state)
         c_FETCH1: begin
            o_GatePC = 1'b1;
            o_LD_MAR = 1'b1;
            o_LD_PC  = 1'b1;
         end
         c_FETCH2: begin
            o_Mem_OE = 1'b1;
            o_LD_MDR = (r_wait == c_WAIT_LAST);
         end
         c_FETCH3: begin
            o_GateMDR = 1'b1;
            o_LD_IR   = 1'b1;
         end
         c_BR_TAKE: begin
            o_LD_PC    = 1'b1;
            o_PCMUX    = 2'b10;
            o_ADDR2MUX = 2'b10;
         end
         c_JMP: begin
            o_LD_PC    = 1'b1;
            o_PCMUX    = 2'b10;
            o_ADDR1MUX = 1'b1;
         end
         c_JSR_LINK: begin
            o_GatePC = 1'b1;
            o_LD_REG = 1'b1;
            o_DRMUX  = 1'b1;
         end
         c_JSR_TARGET: begin
            o_LD_PC    = 1'b1;
            o_PCMUX    = 2'b10;
            o_ADDR1MUX = ~i_IR[11];
            o_ADDR2MUX = i_IR[11] ? 2'b11 : 2'b00;
         end
         c_EXEC_WAIT:  o_exec_req = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_lc3_fetch_sequencer.sv
// ============================================================================
// tb_lc3_fetch_sequencer : directed scoreboard bench for lc3_fetch_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lc3_fetch_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, i_Run, i_Continue, i_exec_done;
   logic [15:0] i_IR;
   logic [2:0]  i_nzp;
   logic        o_exec_req, o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG;
   logic        o_GatePC, o_GateMDR, o_ADDR1MUX, o_DRMUX, o_Mem_OE;
   logic [1:0]  o_PCMUX, o_ADDR2MUX;
   logic [3:0]  o_state_dbg;

   lc3_fetch_sequencer #(.MEM_WAIT(2)) dut (
      .Clk(Clk), .Reset(Reset), .i_Run(i_Run), .i_Continue(i_Continue),
      .i_IR(i_IR), .i_nzp(i_nzp), .i_exec_done(i_exec_done),
      .o_exec_req(o_exec_req), .o_LD_MAR(o_LD_MAR), .o_LD_MDR(o_LD_MDR),
      .o_LD_IR(o_LD_IR), .o_LD_PC(o_LD_PC), .o_LD_REG(o_LD_REG),
      .o_GatePC(o_GatePC), .o_GateMDR(o_GateMDR), .o_PCMUX(o_PCMUX),
      .o_ADDR1MUX(o_ADDR1MUX), .o_ADDR2MUX(o_ADDR2MUX), .o_DRMUX(o_DRMUX),
      .o_Mem_OE(o_Mem_OE), .o_state_dbg(o_state_dbg)
   );

   always #5 Clk = ~Clk;

   // {exec_req, LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, GatePC, GateMDR, PCMUX[1:0], ADDR1MUX, ADDR2MUX[1:0], DRMUX, Mem_OE}
   logic [14:0] w_obs;
   assign w_obs = {o_exec_req, o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG,
                   o_GatePC, o_GateMDR, o_PCMUX, o_ADDR1MUX, o_ADDR2MUX, o_DRMUX, o_Mem_OE};

   localparam logic [14:0] c_B_EXEC  = 15'h4000;
   localparam logic [14:0] c_B_MAR   = 15'h2000;
   localparam logic [14:0] c_B_MDR   = 15'h1000;
   localparam logic [14:0] c_B_IR    = 15'h0800;
   localparam logic [14:0] c_B_PC    = 15'h0400;
   localparam logic [14:0] c_B_REG   = 15'h0200;
   localparam logic [14:0] c_B_GPC   = 15'h0100;
   localparam logic [14:0] c_B_GMDR  = 15'h0080;
   localparam logic [14:0] c_B_PCADD = 15'h0040;
   localparam logic [14:0] c_B_A1    = 15'h0010;
   localparam logic [14:0] c_B_A2OF9 = 15'h0008;
   localparam logic [14:0] c_B_A2OFB = 15'h000C;
   localparam logic [14:0] c_B_DR    = 15'h0002;
   localparam logic [14:0] c_B_OE    = 15'h0001;

   localparam logic [14:0] c_IDLE = 15'h0000;
   localparam logic [14:0] c_F1   = c_B_GPC | c_B_MAR | c_B_PC;
   localparam logic [14:0] c_F2   = c_B_OE;
   localparam logic [14:0] c_F2L  = c_B_OE | c_B_MDR;
   localparam logic [14:0] c_F3   = c_B_GMDR | c_B_IR;
   localparam logic [14:0] c_BRT  = c_B_PC | c_B_PCADD | c_B_A2OF9;
   localparam logic [14:0] c_JMPE = c_B_PC | c_B_PCADD | c_B_A1;
   localparam logic [14:0] c_JSRL = c_B_GPC | c_B_REG | c_B_DR;
   localparam logic [14:0] c_JSRO = c_B_PC | c_B_PCADD | c_B_A2OFB;
   localparam logic [14:0] c_JSRR = c_B_PC | c_B_PCADD | c_B_A1;
   localparam logic [14:0] c_EXE  = c_B_EXEC;

   typedef struct {
      string       tag;
      logic [14:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  halted_code;

   task automatic push_exp(input string tag, input logic [14:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic tick_check();
      exp_t e;
      @(posedge Clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %h required an expectation", w_obs);
      end else begin
         e = sb.pop_front();
         assert (w_obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, w_obs, e.exp);
         end
      end
   endtask

   task automatic cyc(input string tag, input logic [14:0] exp);
      push_exp(tag, exp);
      tick_check();
   endtask

   initial begin
      Reset = 1'b1; i_Run = 1'b1; i_Continue = 1'b0; i_exec_done = 1'b0;
      i_IR = 16'h1021; i_nzp = 3'b010;
      cyc("reset_run_ignored", c_IDLE);
      cyc("reset_hold", c_IDLE);
      halted_code = o_state_dbg;

      // ADD: full fetch then hand-off to execute controller
      Reset = 1'b0;
      cyc("add_fetch1", c_F1);
      cyc("add_fetch2_a", c_F2);
      cyc("add_fetch2_mdr", c_F2L);
      cyc("add_fetch3", c_F3);
      cyc("add_decode", c_IDLE);
      cyc("add_exec_req", c_EXE);
      cyc("add_exec_hold", c_EXE);
      i_Run = 1'b0;
      cyc("add_run_drop_hold", c_EXE);
      i_exec_done = 1'b1;
      cyc("add_done_to_halt", c_IDLE);
      i_exec_done = 1'b0;
      cyc("halt_stays", c_IDLE);

      // BRnp not taken, spurious exec_done during fetch
      i_Run = 1'b1; i_IR = 16'h0A05; i_nzp = 3'b010;
      cyc("brn_fetch1", c_F1);
      i_exec_done = 1'b1;
      cyc("spur_done_f2a", c_F2);
      cyc("spur_done_f2l", c_F2L);
      i_exec_done = 1'b0;
      cyc("brn_fetch3", c_F3);
      cyc("brn_decode", c_IDLE);
      cyc("brn_next_fetch1", c_F1);
      cyc("pre_reset_f2", c_F2);

      // reset in the middle of the memory wait
      Reset = 1'b1;
      cyc("reset_mid_f2", c_IDLE);
      cyc("reset_mid_f2_hold", c_IDLE);
      Reset = 1'b0; i_nzp = 3'b100;
      cyc("brt_fetch1", c_F1);
      cyc("brt_fetch2_a", c_F2);
      cyc("brt_fetch2_mdr", c_F2L);
      cyc("brt_fetch3", c_F3);
      cyc("brt_decode", c_IDLE);
      cyc("br_take", c_BRT);
      cyc("brt_next_fetch1", c_F1);

      // JSR with PC-relative offset
      i_IR = 16'h4805;
      cyc("jsr_fetch2_a", c_F2);
      cyc("jsr_fetch2_mdr", c_F2L);
      cyc("jsr_fetch3", c_F3);
      cyc("jsr_decode", c_IDLE);
      cyc("jsr_link", c_JSRL);
      cyc("jsr_target", c_JSRO);
      cyc("jsr_next_fetch1", c_F1);

      // JSRR through R2
      i_IR = 16'h4080;
      cyc("jsrr_fetch2_a", c_F2);
      cyc("jsrr_fetch2_mdr", c_F2L);
      cyc("jsrr_fetch3", c_F3);
      cyc("jsrr_decode", c_IDLE);
      cyc("jsrr_link", c_JSRL);
      cyc("jsrr_target", c_JSRR);
      cyc("jsrr_next_fetch1", c_F1);

      // JMP R2
      i_IR = 16'hC080;
      cyc("jmp_fetch2_a", c_F2);
      cyc("jmp_fetch2_mdr", c_F2L);
      cyc("jmp_fetch3", c_F3);
      cyc("jmp_decode", c_IDLE);
      cyc("jmp_exec", c_JMPE);
      cyc("jmp_next_fetch1", c_F1);

      // PSE with Continue already high: must not release until a fresh rising edge
      i_IR = 16'hD000; i_Continue = 1'b1;
      cyc("pse_fetch2_a", c_F2);
      cyc("pse_fetch2_mdr", c_F2L);
      cyc("pse_fetch3", c_F3);
      cyc("pse_decode", c_IDLE);
      cyc("pause_hold_1", c_IDLE);
      cyc("pause_hold_2", c_IDLE);
      checks++;
      assert (o_state_dbg !== halted_code) else begin
         errors++;
         $error("FAIL pause_not_halted: observed state %h must differ from halted %h", o_state_dbg, halted_code);
      end
      i_Continue = 1'b0;
      cyc("pause_cont_low", c_IDLE);
      i_Continue = 1'b1;
      cyc("pause_release_fetch1", c_F1);

      // Run dropped mid-fetch: BR not taken completes, then halt
      i_Run = 1'b0; i_IR = 16'h0A05; i_nzp = 3'b010;
      cyc("last_fetch2_a", c_F2);
      cyc("last_fetch2_mdr", c_F2L);
      cyc("last_fetch3", c_F3);
      cyc("last_decode", c_IDLE);
      cyc("last_halt", c_IDLE);
      cyc("last_halt_hold", c_IDLE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
